// File: rtl/alu_hex_display_if.sv
// -----------------------------------------------------------------------------
// alu_hex_display_if
// Bundles the operand/capture inputs and the result/display outputs of
// alu_hex_display.
//   master : drives a, b, op, load; observes result, carry, valid, an, seg, dp
//   slave  : the ALU/display block (receives operands, drives outputs)
// Signals:
//   a, b   [WIDTH-1:0]  operands
//   op     [1:0]        00 AND, 01 OR, 10 XOR, 11 ADD
//   load                capture strobe
//   result [WIDTH-1:0]  registered result
//   carry               registered carry-out (ADD only)
//   valid               one-cycle pulse after each capture
//   an     [DIGITS-1:0] digit enables, active-low, one-hot-low
//   seg    [6:0]        segments {g,f,e,d,c,b,a}, active-low
//   dp                  decimal point, active-low (always off)
// -----------------------------------------------------------------------------
interface alu_hex_display_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 4
);
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [1:0]        op;
    logic              load;
    logic [WIDTH-1:0]  result;
    logic              carry;
    logic              valid;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              dp;

    modport master (
        output a, b, op, load,
        input  result, carry, valid, an, seg, dp
    );

    modport slave (
        input  a, b, op, load,
        output result, carry, valid, an, seg, dp
    );
endinterface

// File: rtl/alu_hex_display.sv
// -----------------------------------------------------------------------------
// alu_hex_display
// Registered two-operand AND/OR/XOR/ADD unit whose captured {carry,result}
// is shown in hex on a multiplexed common-anode 7-segment display.
// Ports:
//   clk  : system clock (only clock)
//   rst  : synchronous active-high reset, priority over load
//   bus  : alu_hex_display_if.slave (operands, capture strobe, result and
//          display outputs; see the interface file for the signal list)
// Parameters:
//   WIDTH       operand/result width (>=1)
//   DIGITS      number of display digits (>=1)
//   REFRESH_DIV cycles each digit stays lit (>=1)
// -----------------------------------------------------------------------------
module alu_hex_display #(
    parameter int WIDTH       = 4,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    alu_hex_display_if.slave bus
);
    // Counter widths are kept at least 1 bit so REFRESH_DIV=1 / DIGITS=1 work.
    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FULL_W = WIDTH + 1;
    localparam int V_W    = 4 * DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;

    logic [FULL_W-1:0] w_calc;
    logic [FULL_W-1:0] w_full;
    logic [V_W-1:0]    w_v;
    logic [3:0]        w_nibbles [DIGITS];
    logic [3:0]        w_nib;
    logic [6:0]        w_seg;

    // Next {carry,result}; logic ops leave the carry bit at zero.
    always_comb begin
        w_calc = '0;
        case (bus.op)
            2'b00:   w_calc = {1'b0, bus.a & bus.b};
            2'b01:   w_calc = {1'b0, bus.a | bus.b};
            2'b10:   w_calc = {1'b0, bus.a ^ bus.b};
            default: w_calc = {1'b0, bus.a} + {1'b0, bus.b};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
            r_idx    <= '0;
        end else begin
            if (bus.load) begin
                {r_carry, r_result} <= w_calc;
            end
            r_valid <= bus.load;

            // Free-running scan, independent of captures.
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_full = {r_carry, r_result};

    // Displayed value: {carry,result} fitted to exactly DIGITS nibbles.
    generate
        if (FULL_W >= V_W) begin : g_trunc
            assign w_v = w_full[V_W-1:0];
        end else begin : g_zext
            assign w_v = {{(V_W - FULL_W){1'b0}}, w_full};
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_nibbles[gi] = w_v[4*gi +: 4];
            assign bus.an[gi]    = (r_idx != IDX_W'(gi));
        end
    endgenerate

    assign w_nib = w_nibbles[r_idx];

    // Active-low {g,f,e,d,c,b,a} hex glyphs.
    always_comb begin
        w_seg = 7'b1111111;
        case (w_nib)
            4'h0: w_seg = 7'b1000000;
            4'h1: w_seg = 7'b1111001;
            4'h2: w_seg = 7'b0100100;
            4'h3: w_seg = 7'b0110000;
            4'h4: w_seg = 7'b0011001;
            4'h5: w_seg = 7'b0010010;
            4'h6: w_seg = 7'b0000010;
            4'h7: w_seg = 7'b1111000;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0010000;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b0000011;
            4'hC: w_seg = 7'b1000110;
            4'hD: w_seg = 7'b0100001;
            4'hE: w_seg = 7'b0000110;
            default: w_seg = 7'b0001110;
        endcase
    end

    assign bus.result = r_result;
    assign bus.carry  = r_carry;
    assign bus.valid  = r_valid;
    assign bus.seg    = w_seg;
    assign bus.dp     = 1'b1;
endmodule

// File: doc/alu_hex_display.md
# alu_hex_display

Registered, parametrised two-operand logic/arithmetic unit with a built-in multiplexed 7-segment hex display driver. It generalises the board's single combinational AND gate in three ways: configurable operand width, selectable operation (AND/OR/XOR/ADD with carry), and a captured result shown on the board's common-anode display. It sits between the switch/button inputs and the display pins in the AdderWithDisplay design.

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width in bits (≥1).
- `DIGITS`, default 4: number of 7-segment digits driven (≥1).
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit (≥1).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `op`  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 ADD.
- `load`  in  1  capture strobe; samples `a`, `b`, `op` on the rising edge.
- `result`  out  WIDTH  registered result.
- `carry`  out  1  registered carry-out (ADD only).
- `valid`  out  1  one-cycle pulse per capture.
- `an`  out  DIGITS  digit enables, active-low, one-hot-low.
- `seg`  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- `dp`  out  1  decimal point, active-low; held 1 (off).

## Operation
- Capture:
  - When `load`=1 at an edge, `result` is set to `op(a,b)`.
  - For ADD, `{carry,result}` is set to the (WIDTH+1)-bit sum `a+b`. For logic ops, `carry` is 0.
  - Without `load`, `result` and `carry` hold regardless of changes on `a`, `b` or `op`.
- `valid` is registered `load`: high the cycle after each capture edge. If `load` is held high, `result` updates and `valid` stays high every cycle.
- Display value `V` is `{carry,result}` zero-extended or truncated to 4·DIGITS bits. Digit i shows nibble `V[4i+3:4i]`. Digit 0 is least significant.
- Hex encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Refresh:
  - Counter `cnt` runs 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index `idx` advances 0→1→…→DIGITS-1→0.
  - REFRESH_DIV=1 advances `idx` every cycle. DIGITS=1 keeps `idx` at 0.
- `an` and `seg` are combinational decodes of registered `idx` and `V`:
  - `an[idx]`=0; all other bits 1.
  - `seg` = encoding of nibble `idx`.
- Reset (synchronous, priority over `load`):
  - `result`=0, `carry`=0, `valid`=0, `cnt`=0, `idx`=0.
  - Outputs read `an`=~1 (digit 0 lit), `seg`=1000000, `dp`=1.

## Timing
- Capture latency:
  - Edge N samples `load`=1.
  - `result`, `carry` and `valid` are valid after edge N.
  - `seg` reflects the new value in the same cycle, for whichever digit is lit.
- `valid` deasserts after edge N+1 unless `load` is sampled high again.
- Digit dwell is exactly REFRESH_DIV cycles. Full scan period is REFRESH_DIV·DIGITS cycles.
- Capture does not disturb `cnt` or `idx`. The scan is free-running except on reset.
- `rst` and `load` high together: reset wins; no capture and no `valid` pulse.
- Reset mid-scan: the cycle after the `rst` edge shows `an`=…1110 and restarts a full dwell.
- No handshake back-pressure. `load` may be asserted any cycle.
- Inputs are synchronous to `clk`. Debouncing and synchronisation are done upstream.

## Test plan
Bench parameters: WIDTH=4, DIGITS=4, REFRESH_DIV=4.
- Reset: assert `rst` 2 cycles → `result`=0, `carry`=0, `valid`=0, `an`=1110, `seg`=1000000, `dp`=1.
- ADD overflow: `a`=F, `b`=1, `op`=11, `load` pulsed 1 cycle → next cycle `result`=0, `carry`=1, `valid`=1 for exactly 1 cycle. Digit 0 shows `seg`=1000000; digit 1 shows `seg`=1111001 (V=0x0010).
- Logic ops with hold:
  - AND `a`=C, `b`=A → `result`=8, `carry`=0, digit 0 `seg`=0000000.
  - Then XOR `a`=5, `b`=F → `result`=A, digit 0 `seg`=0001000.
  - Then change `a`/`b` with `load`=0 → `result` stays A.
- Scan sequence: idle after reset → `an`=1110 for 4 cycles, then 1101, 1011, 0111 for 4 cycles each. Returns to 1110 at cycle 16. Exactly one `an` bit is low at all times.
- Held load: `load`=1 for 3 cycles with OR `a`=3, `b`=4, then `b`=8 → `valid` high 3 consecutive cycles; `result` goes 7 then B.
- Reset collision: `rst`=1 and `load`=1 (ADD 9+9) in the same cycle mid-scan (`an`=1011) → `result`=0, `carry`=0, `valid`=0. `an` returns to 1110 and dwells a full 4 cycles.
